// File: rtl/minimicro_ctrl.sv
// Multicycle control sequencer for the miniMicro core: FETCH/LATCH/DECODE/EXEC/WAIT/WB.
// Optional single-step mode and retired-instruction counter under `MINIMICRO_STEP_EN.
module minimicro_ctrl #(
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned DEST_WIDTH   = 9,
    parameter int unsigned SRC1_WIDTH   = 9,
    parameter int unsigned SRC2_WIDTH   = 9,
    parameter int unsigned MAX_OPCODE   = 18,
    parameter int unsigned ALU_TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_run,
    input  logic [31:0]             i_instruction,
    input  logic                    i_alu_done,
`ifdef MINIMICRO_STEP_EN
    input  logic                    i_step,
    output logic [31:0]             o_retired,
`endif
    output logic                    o_pc_inc,
    output logic                    o_ir_load,
    output logic                    o_reg_re,
    output logic [SRC1_WIDTH-1:0]   o_rs1_addr,
    output logic [SRC2_WIDTH-1:0]   o_rs2_addr,
    output logic [DEST_WIDTH-1:0]   o_rd_addr,
    output logic [OPCODE_WIDTH-1:0] o_alu_op,
    output logic                    o_alu_start,
    output logic                    o_reg_we,
    output logic                    o_flags_we,
    output logic                    o_trap,
    output logic                    o_busy
);

    localparam int unsigned RS1_LSB = SRC2_WIDTH;
    localparam int unsigned RD_LSB  = SRC1_WIDTH + SRC2_WIDTH;
    localparam int unsigned OP_LSB  = DEST_WIDTH + SRC1_WIDTH + SRC2_WIDTH;
    localparam int unsigned CNT_W   = $clog2(ALU_TIMEOUT + 1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MAX   = OPCODE_WIDTH'(MAX_OPCODE);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StLatch, StDecode, StExec, StWait, StWb, StTrap
    } state_e;

    state_e                  r_state;
    logic [31:0]             r_ir;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_pc_inc, r_ir_load, r_reg_re, r_alu_start;
    logic                    r_reg_we, r_flags_we, r_trap, r_busy;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic                    w_is_alu, w_writes_reg, w_start, w_wb_fetch;

    assign w_opcode     = r_ir[OP_LSB +: OPCODE_WIDTH];
    assign w_is_alu     = (w_opcode != '0) && (w_opcode <= OP_MAX);
    // The top legal opcode (CMP) only updates flags.
    assign w_writes_reg = w_is_alu && (w_opcode != OP_MAX);

`ifdef MINIMICRO_STEP_EN
    logic        r_step_q;
    logic [31:0] r_retired;
    assign w_start    = i_run && i_step && !r_step_q;
    assign w_wb_fetch = 1'b0;
    assign o_retired  = r_retired;
`else
    assign w_start    = i_run;
    assign w_wb_fetch = i_run;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ir        <= '0;
            r_cnt       <= '0;
            r_pc_inc    <= 1'b0;
            r_ir_load   <= 1'b0;
            r_reg_re    <= 1'b0;
            r_alu_start <= 1'b0;
            r_reg_we    <= 1'b0;
            r_flags_we  <= 1'b0;
            r_trap      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MINIMICRO_STEP_EN
            r_step_q    <= 1'b0;
            r_retired   <= '0;
`endif
        end else begin
            r_pc_inc    <= 1'b0;
            r_ir_load   <= 1'b0;
            r_reg_re    <= 1'b0;
            r_alu_start <= 1'b0;
            r_reg_we    <= 1'b0;
            r_flags_we  <= 1'b0;
`ifdef MINIMICRO_STEP_EN
            r_step_q    <= i_step;
`endif
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state <= StFetch;
                        r_busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    r_state   <= StLatch;
                    r_ir_load <= 1'b1;
                end
                StLatch: begin
                    r_ir     <= i_instruction;
                    r_state  <= StDecode;
                    r_reg_re <= 1'b1;
                end
                StDecode: begin
                    if (w_opcode == '0) begin
                        r_state  <= StWb;
                        r_pc_inc <= 1'b1;
                    end else if (w_is_alu) begin
                        r_state     <= StExec;
                        r_alu_start <= 1'b1;
                    end else begin
                        r_state <= StTrap;
                        r_trap  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                StExec: begin
                    r_state <= StWait;
                    r_cnt   <= '0;
                end
                StWait: begin
                    if (i_alu_done) begin
                        r_state    <= StWb;
                        r_pc_inc   <= 1'b1;
                        r_reg_we   <= w_writes_reg;
                        r_flags_we <= w_is_alu;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= StTrap;
                        r_trap  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StWb: begin
`ifdef MINIMICRO_STEP_EN
                    r_retired <= r_retired + 32'd1;
`endif
                    if (w_wb_fetch) begin
                        r_state <= StFetch;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StTrap: begin
                    r_state <= StTrap;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_pc_inc    = r_pc_inc;
    assign o_ir_load   = r_ir_load;
    assign o_reg_re    = r_reg_re;
    assign o_alu_start = r_alu_start;
    assign o_reg_we    = r_reg_we;
    assign o_flags_we  = r_flags_we;
    assign o_trap      = r_trap;
    assign o_busy      = r_busy;
    assign o_alu_op    = w_opcode;
    assign o_rd_addr   = r_ir[RD_LSB +: DEST_WIDTH];
    assign o_rs1_addr  = r_ir[RS1_LSB +: SRC1_WIDTH];
    assign o_rs2_addr  = r_ir[0 +: SRC2_WIDTH];

endmodule

// File: tb/tb_minimicro_ctrl.sv
// Directed bench for minimicro_ctrl with a per-instruction expectation queue.
module tb_minimicro_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, alu_done;
    logic [31:0] instr;
    logic        pc_inc, ir_load, reg_re, alu_start, reg_we, flags_we, trap, busy;
    logic [8:0]  rs1, rs2, rd;
    logic [4:0]  alu_op;
`ifdef MINIMICRO_STEP_EN
    logic        step;
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] op;
        logic [8:0] rd, rs1, rs2;
        logic       reg_we, flags_we, trap;
        int         lat, waits, starts;
    } exp_t;
    exp_t sb[$];

    minimicro_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (run),
        .i_instruction (instr),
        .i_alu_done    (alu_done),
`ifdef MINIMICRO_STEP_EN
        .i_step        (step),
        .o_retired     (retired),
`endif
        .o_pc_inc      (pc_inc),
        .o_ir_load     (ir_load),
        .o_reg_re      (reg_re),
        .o_rs1_addr    (rs1),
        .o_rs2_addr    (rs2),
        .o_rd_addr     (rd),
        .o_alu_op      (alu_op),
        .o_alu_start   (alu_start),
        .o_reg_we      (reg_we),
        .o_flags_we    (flags_we),
        .o_trap        (trap),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({pc_inc, ir_load, reg_re, alu_start, reg_we, flags_we, trap});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        alu_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // done_wait: WAIT cycle (1-based) in which alu_done is raised; 0 means never.
    task automatic run_one(input logic [31:0] w, input int done_wait, input bit drop_in_exec);
        exp_t e, got;
        int   cyc, ir_cyc, wait_n, starts, trap_cyc;
        bit   waiting, fin, saw_pc, saw_we, legal, cap_we, cap_fl;
        logic [4:0] cap_op;
        e.op  = w[31:27];
        e.rd  = w[26:18];
        e.rs1 = w[17:9];
        e.rs2 = w[8:0];
        legal      = (e.op >= 5'd1) && (e.op <= 5'd18);
        e.trap     = (e.op > 5'd18) || (legal && done_wait == 0);
        e.waits    = legal ? ((done_wait == 0) ? 16 : done_wait) : 0;
        e.starts   = legal ? 1 : 0;
        e.reg_we   = legal && (e.op <= 5'd17) && !e.trap;
        e.flags_we = legal && !e.trap;
        e.lat      = (e.op == 5'd0) ? 4 : 5 + e.waits;
        sb.push_back(e);
        instr = w;
        run = 1'b1;
        alu_done = 1'b0;
`ifdef MINIMICRO_STEP_EN
        step = 1'b1;
`endif
        cyc = 0; ir_cyc = 0; wait_n = 0; starts = 0; trap_cyc = 0;
        waiting = 0; fin = 0; saw_pc = 0; saw_we = 0; cap_we = 0; cap_fl = 0; cap_op = '0;
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
`ifdef MINIMICRO_STEP_EN
            step = 1'b0;
`endif
            chk("strobe_excl", 32'($countones({ir_load, alu_start, reg_we | pc_inc}) <= 1), 1);
            if (ir_load) ir_cyc = cyc;
            if (reg_re) begin
                chk("dec_op", 32'(alu_op), 32'(sb[0].op));
                chk("dec_rd", 32'(rd), 32'(sb[0].rd));
                chk("dec_rs1", 32'(rs1), 32'(sb[0].rs1));
                chk("dec_rs2", 32'(rs2), 32'(sb[0].rs2));
            end
            if (reg_we) saw_we = 1;
            if (alu_start) begin
                starts++;
                waiting = 1;
                if (drop_in_exec) run = 1'b0;
            end else if (!pc_inc && !trap && waiting) begin
                wait_n++;
                alu_done = (wait_n == done_wait);
            end
            if (pc_inc) begin
                saw_pc = 1; cap_we = reg_we; cap_fl = flags_we; cap_op = alu_op;
                run = 1'b0; alu_done = 1'b0; fin = 1;
            end
            if (trap) begin
                trap_cyc = cyc; fin = 1;
            end
        end
        chk("completed", 32'(fin), 1);
        got = sb.pop_front();
        chk("ir_load_cycle", ir_cyc, 2);
        chk("alu_starts", starts, got.starts);
        chk("wait_cycles", wait_n, got.waits);
        chk("trap", 32'(trap), 32'(got.trap));
        if (got.trap) begin
            chk("trap_no_pc_inc", 32'(saw_pc), 0);
            chk("trap_no_reg_we", 32'(saw_we), 0);
            chk("trap_busy", 32'(busy), 0);
            chk("trap_cycle", trap_cyc, (got.waits == 0) ? 4 : 5 + got.waits);
        end else begin
            chk("latency", cyc, got.lat);
            chk("wb_reg_we", 32'(cap_we), 32'(got.reg_we));
            chk("wb_flags_we", 32'(cap_fl), 32'(got.flags_we));
            chk("wb_alu_op_held", 32'(cap_op), 32'(got.op));
            tick();
            chk("idle_after_wb", 32'(busy), 0);
            chk("idle_strobes", strobes(), 0);
        end
        run = 1'b0;
        alu_done = 1'b0;
    endtask

    initial begin
        int  pc_t[3];
        int  npc, cyc;
        bit  seen, bad;
        instr = '0;
`ifdef MINIMICRO_STEP_EN
        step = 1'b0;
`endif
        rst = 1'b1; run = 1'b0; alu_done = 1'b0;
        tick();
        tick();
        chk("rst_strobes", strobes(), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fields", {alu_op, rd, rs1, rs2}, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_run0_busy", 32'(busy), 0);
        chk("idle_run0_strobes", strobes(), 0);

`ifndef MINIMICRO_STEP_EN
        // Back-to-back ADDS; alu_done held high so it lands on the first WAIT cycle.
        instr = 32'h3024_0802; alu_done = 1'b1; run = 1'b1;
        npc = 0; cyc = 0;
        while (npc < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (pc_inc) begin
                pc_t[npc] = cyc;
                npc++;
                if (npc == 3) run = 1'b0;
            end
        end
        chk("stream_pulses", npc, 3);
        chk("stream_first_wb", pc_t[0], 6);
        chk("stream_gap0", pc_t[1] - pc_t[0], 6);
        chk("stream_gap1", pc_t[2] - pc_t[1], 6);
        alu_done = 1'b0;
        tick();
        chk("stream_idle", 32'(busy), 0);
`endif

        run_one(32'h3024_0802, 1, 0);   // ADDS rd=9 rs1=4 rs2=2
        run_one(32'h9000_0605, 1, 0);   // CMP
        run_one(32'h0000_0000, 1, 0);   // NOP
        run_one(32'h4804_0403, 10, 0);  // MULS, slow ALU
        run_one(32'h1FFF_FFFF, 2, 1);   // op 3, max fields, run dropped in EXEC
        run_one(32'h8800_0001, 1, 0);   // op 17, last register writer

        run_one(32'h4800_0000, 0, 0);   // ALU never answers
        run = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_inc || reg_we || !trap || busy) bad = 1;
        end
        chk("trap_sticky", 32'(bad), 0);
        do_reset();
        tick();
        chk("rst_clears_trap", 32'(trap), 0);

        run_one(32'h9800_0000, 1, 0);   // op 19 illegal
        do_reset();
        run_one(32'hF8FF_FFFF, 1, 0);   // op 31 illegal
        do_reset();
        tick();

        // Reset while waiting on the ALU abandons the instruction.
        instr = 32'h3024_0802; run = 1'b1; alu_done = 1'b0;
`ifdef MINIMICRO_STEP_EN
        step = 1'b1;
`endif
        seen = 0; cyc = 0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
`ifdef MINIMICRO_STEP_EN
            step = 1'b0;
`endif
            if (alu_start) seen = 1;
        end
        chk("mid_reach_exec", 32'(seen), 1);
        tick();
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_strobes", strobes(), 0);
        chk("mid_rst_ir", {alu_op, rd, rs1, rs2}, 0);
        alu_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pc_inc || reg_we || busy) bad = 1;
        end
        chk("mid_rst_no_wb", 32'(bad), 0);
        alu_done = 1'b0;

`ifdef MINIMICRO_STEP_EN
        do_reset();
        instr = 32'h3024_0802; run = 1'b1; alu_done = 1'b1; step = 1'b0;
        npc = 0;
        for (int p = 0; p < 3; p++) begin
            tick();
            step = 1'b1;
            tick();
            step = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (pc_inc) npc++;
                tick();
            end
        end
        chk("step_pc_inc", npc, 3);
        chk("step_retired", retired, 3);
        run = 1'b0; alu_done = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
